mem_io_responder: RTL

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus a memory-mapped UART tx FIFO and halt register.
// Optional IO_CYCLE_COUNTER_EN adds a 32-bit cycle counter readable at IO 0x30004..0x30007.
`default_nettype none

module mem_io_responder #(
  parameter int RAM_ADDR_WID = 17,
  parameter int FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_overflow,
  output logic        halt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;

  logic [7:0] ram      [0:(1 << RAM_ADDR_WID) - 1];
  logic [7:0] fifo_mem [0:DEPTH - 1];

  logic [7:0]         rdata_q, rdata_d;
  logic               buf_full_q, buf_full_d;
  logic               overflow_q, overflow_d;
  logic               halt_q, halt_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic                    is_io;
  logic [15:0]             io_off;
  logic [RAM_ADDR_WID-1:0] ram_addr;
  logic                    ram_we;
  logic                    push_req;
  logic                    halt_req;
  logic                    fifo_full;
  logic                    pop;
  logic                    push_ok;
  logic [7:0]              io_rdata;
  logic                    unused_bus_a;

  // Only the low 18 address bits take part in decode.
  assign unused_bus_a = ^bus_a[31:18];

  assign is_io    = (bus_a[17:16] == 2'b11);
  assign io_off   = bus_a[15:0];
  assign ram_addr = bus_a[RAM_ADDR_WID-1:0];
  assign ram_we   = rdy && bus_wr && !is_io && !rst;
  assign push_req = rdy && bus_wr && is_io && (io_off == 16'h0000) && !rst;
  assign halt_req = rdy && bus_wr && is_io && (io_off == 16'h0004);

  assign fifo_full = (count_q == CNT_W'(DEPTH));
  assign pop       = (count_q != '0) && tx_ready && !rst;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req && (!fifo_full || pop);

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (rdy) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  always_comb begin
    io_rdata = 8'h00;
    if (io_off == 16'h0001)          io_rdata = {7'b0, buf_full_q};
    else if (io_off[15:2] == 14'h1)  io_rdata = cyc_q[{io_off[1:0], 3'b000} +: 8];
  end
`else
  always_comb begin
    io_rdata = 8'h00;
    if (io_off == 16'h0001) io_rdata = {7'b0, buf_full_q};
  end
`endif

  always_comb begin
    rdata_d    = rdata_q;
    overflow_d = overflow_q;
    halt_d     = halt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (rdy && !bus_wr) rdata_d = is_io ? io_rdata : ram[ram_addr];

    if (push_req && !push_ok) overflow_d = 1'b1;
    if (halt_req)             halt_d     = 1'b1;

    if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);

    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

    // Two entries of margin cover the initiator's check-then-write delay.
    buf_full_d = (count_d >= CNT_W'(DEPTH - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      buf_full_q <= 1'b0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rdata_q    <= rdata_d;
      buf_full_q <= buf_full_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage arrays carry no reset so they map onto RAM macros.
  always_ff @(posedge clk) begin
    if (ram_we)  ram[ram_addr]        <= bus_wdata;
    if (push_ok) fifo_mem[wr_ptr_q]   <= bus_wdata;
  end

  assign bus_rdata      = rdata_q;
  assign io_buffer_full = buf_full_q;
  assign tx_data        = fifo_mem[rd_ptr_q];
  assign tx_valid       = (count_q != '0);
  assign tx_overflow    = overflow_q;
  assign halt           = halt_q;

endmodule

`default_nettype wire
